// File: rtl/door_controller.sv
// door_controller: per-car door sequencer.
// Opens the stationary car's door when a call or the open button needs service at the
// current floor. It then times the opening, dwell and closing phases and reacts to the
// open/close buttons and the obstruction sensor. door_closed gates car motion downstream.
module door_controller #(
   parameter int TRAVEL_CYCLES = 3,
   parameter int DWELL_CYCLES  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  current_floor,
   input  logic [1:0]  current_direction,
   input  logic [13:0] floor_button,
   input  logic [6:0]  car_button,
   input  logic        lift_stopped,
   input  logic        open_btn,
   input  logic        close_btn,
   input  logic        obstruction,
   output logic        door_state,
   output logic        door_closed,
   output logic [1:0]  door_motor,
   output logic        door_fault
);

   localparam int MAX_CYCLES = (TRAVEL_CYCLES > DWELL_CYCLES) ? TRAVEL_CYCLES : DWELL_CYCLES;
   localparam int TW         = $clog2(MAX_CYCLES) + 1;

   localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0] DWELL_LOAD  = TW'(DWELL_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
   localparam logic [TW-1:0] TIMER_ZERO  = '0;

   typedef enum logic [1:0] {
      ST_CLOSED  = 2'd0,
      ST_OPENING = 2'd1,
      ST_OPEN    = 2'd2,
      ST_CLOSING = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            fault_q, fault_d;

   // Padded copies so that floor 7 indexes a defined zero bit instead of running off the end.
   logic [15:0]     fb_pad;
   logic [7:0]      cb_pad;
   logic            dir_idle;
   logic            up_ok;
   logic            down_ok;
   logic            service;
   logic            reopen_req;

   assign fb_pad     = {2'b00, floor_button};
   assign cb_pad     = {1'b0, car_button};
   assign reopen_req = obstruction | open_btn;

   // Decide whether the car, standing at a real floor, has a reason to open its door.
   always_comb begin
      dir_idle = (current_direction == 2'b00);
      up_ok    = fb_pad[{current_floor, 1'b0}] & (current_direction[0] | dir_idle);
      down_ok  = fb_pad[{current_floor, 1'b1}] & (current_direction[1] | dir_idle);
      service  = 1'b0;
      if (lift_stopped && (current_floor != 3'd7)) begin
         service = cb_pad[current_floor] | open_btn | up_ok | down_ok;
      end
   end

   // State, phase timer and sticky fault registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLOSED;
         timer_q <= TIMER_ZERO;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         fault_q <= fault_d;
      end
   end

   // Next-state and timer logic; an open request always beats a close request.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      fault_d = fault_q | (~lift_stopped & (state_q != ST_CLOSED));
      unique case (state_q)
         ST_CLOSED: begin
            if (service) begin
               state_d = ST_OPENING;
               timer_d = TRAVEL_LOAD;
            end
         end
         ST_OPENING: begin
            if (timer_q == TIMER_ZERO) begin
               state_d = ST_OPEN;
               timer_d = DWELL_LOAD;
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         ST_OPEN: begin
            if (reopen_req) begin
               timer_d = DWELL_LOAD;
            end else if (close_btn || (timer_q == TIMER_ZERO)) begin
               state_d = ST_CLOSING;
               timer_d = TRAVEL_LOAD;
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         ST_CLOSING: begin
            if (reopen_req) begin
               state_d = ST_OPENING;
               timer_d = TRAVEL_LOAD;
            end else if (timer_q == TIMER_ZERO) begin
               state_d = ST_CLOSED;
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         default: begin
            state_d = ST_CLOSED;
            timer_d = TIMER_ZERO;
         end
      endcase
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      door_state  = (state_q == ST_OPEN);
      door_closed = (state_q == ST_CLOSED);
      door_motor  = 2'b00;
      if (state_q == ST_OPENING) begin
         door_motor = 2'b01;
      end else if (state_q == ST_CLOSING) begin
         door_motor = 2'b10;
      end
      door_fault  = fault_q;
   end

endmodule

// File: tb/tb_door_controller.sv
// tb_door_controller: directed bench for door_controller with a phase-countdown reference model.
module tb_door_controller;

   localparam int TRAVEL = 3;
   localparam int DWELL  = 8;

   localparam int PH_SHUT    = 0;
   localparam int PH_RISING  = 1;
   localparam int PH_HELD    = 2;
   localparam int PH_FALLING = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  current_floor = 3'd2;
   logic [1:0]  current_direction = 2'b01;
   logic [13:0] floor_button = '0;
   logic [6:0]  car_button = '0;
   logic        lift_stopped = 1'b1;
   logic        open_btn = 1'b0;
   logic        close_btn = 1'b0;
   logic        obstruction = 1'b0;
   logic        door_state;
   logic        door_closed;
   logic [1:0]  door_motor;
   logic        door_fault;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   int m_phase = PH_SHUT;
   int m_left  = 0;
   bit m_fault = 1'b0;

   always #5 clk = ~clk;

   door_controller #(
      .TRAVEL_CYCLES(TRAVEL),
      .DWELL_CYCLES (DWELL)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .current_floor    (current_floor),
      .current_direction(current_direction),
      .floor_button     (floor_button),
      .car_button       (car_button),
      .lift_stopped     (lift_stopped),
      .open_btn         (open_btn),
      .close_btn        (close_btn),
      .obstruction      (obstruction),
      .door_state       (door_state),
      .door_closed      (door_closed),
      .door_motor       (door_motor),
      .door_fault       (door_fault)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Does anything at the car's floor ask for the door?
   function automatic bit wants_door();
      int  f;
      bit  going_up, going_down, idle;
      if (!lift_stopped || current_floor == 3'd7) return 1'b0;
      f          = int'(current_floor);
      idle       = (current_direction == 2'b00);
      going_up   = current_direction[0] || idle;
      going_down = current_direction[1] || idle;
      if (car_button[f] || open_btn) return 1'b1;
      if (floor_button[2*f] && going_up) return 1'b1;
      if (floor_button[2*f+1] && going_down) return 1'b1;
      return 1'b0;
   endfunction

   // Reference model: m_left counts the cycles still to be spent in the current phase.
   always @(posedge clk) begin
      int ph;
      int lf;
      bit fl;
      bit wants_open;
      ph = m_phase;
      lf = m_left;
      fl = m_fault;
      wants_open = obstruction || open_btn;
      if (reset) begin
         ph = PH_SHUT;
         lf = 0;
         fl = 1'b0;
      end else begin
         if (!lift_stopped && m_phase != PH_SHUT) fl = 1'b1;
         case (m_phase)
            PH_SHUT: begin
               if (wants_door()) begin ph = PH_RISING; lf = TRAVEL; end
            end
            PH_RISING: begin
               if (lf <= 1) begin ph = PH_HELD; lf = DWELL; end
               else lf = lf - 1;
            end
            PH_HELD: begin
               if (wants_open) lf = DWELL;
               else if (close_btn || lf <= 1) begin ph = PH_FALLING; lf = TRAVEL; end
               else lf = lf - 1;
            end
            default: begin
               if (wants_open) begin ph = PH_RISING; lf = TRAVEL; end
               else if (lf <= 1) begin ph = PH_SHUT; lf = 0; end
               else lf = lf - 1;
            end
         endcase
      end
      m_phase <= ph;
      m_left  <= lf;
      m_fault <= fl;
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_door_state", {7'd0, door_state}, {7'd0, (m_phase == PH_HELD)});
         chk("model_door_closed", {7'd0, door_closed}, {7'd0, (m_phase == PH_SHUT)});
         chk("model_door_motor", {6'd0, door_motor},
             (m_phase == PH_RISING) ? 8'd1 : (m_phase == PH_FALLING) ? 8'd2 : 8'd0);
         chk("model_door_fault", {7'd0, door_fault}, {7'd0, m_fault});
      end
   end

   initial begin
      int n_open;
      int n_closed;

      // Reset
      @(posedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_door_state", {7'd0, door_state}, 8'd0);
      chk("rst_door_closed", {7'd0, door_closed}, 8'd1);
      chk("rst_door_motor", {6'd0, door_motor}, 8'd0);
      chk("rst_door_fault", {7'd0, door_fault}, 8'd0);
      @(negedge clk);

      // Default up call at floor 2 while travelling up
      floor_button = 14'd1 << 4;
      n_open = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (door_state) n_open++;
         if (k <= 3) chk("dflt_opening_motor", {6'd0, door_motor}, 8'd1);
         if (k == 4) chk("dflt_open_cycle4", {7'd0, door_state}, 8'd1);
         if (k == 11) chk("dflt_open_last", {7'd0, door_state}, 8'd1);
         if (k == 12) chk("dflt_closing_motor", {6'd0, door_motor}, 8'd2);
         if (k == 14) chk("dflt_closing_end", {6'd0, door_motor}, 8'd2);
         if (k == 15) chk("dflt_closed_cycle15", {7'd0, door_closed}, 8'd1);
         if (k == 5) floor_button = '0;
      end
      chk("dflt_open_count", 8'(n_open), 8'd8);

      // Down call while travelling up: no service
      floor_button = 14'd1 << 5;
      n_closed = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (door_closed) n_closed++;
      end
      chk("downcall_stays_closed", 8'(n_closed), 8'd4);
      floor_button = '0;

      // Floor 7 is no floor: nothing opens the door
      current_floor = 3'd7;
      car_button    = 7'h7f;
      open_btn      = 1'b1;
      n_closed = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (door_closed) n_closed++;
      end
      chk("floor7_stays_closed", 8'(n_closed), 8'd4);
      car_button    = '0;
      open_btn      = 1'b0;
      current_floor = 3'd2;
      @(negedge clk);

      // Obstruction while OPEN restarts the dwell
      car_button = 7'd1 << 2;
      n_open = 0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (k >= 14 && k <= 22 && door_state) n_open++;
         if (k == 9) chk("obst_open_before", {7'd0, door_state}, 8'd1);
         if (k == 13) chk("obst_held", {7'd0, door_state}, 8'd1);
         if (k == 21) chk("obst_dwell_last", {7'd0, door_state}, 8'd1);
         if (k == 22) chk("obst_then_closing", {6'd0, door_motor}, 8'd2);
         if (k == 25) chk("obst_closed", {7'd0, door_closed}, 8'd1);
         if (k == 1) car_button = '0;
         if (k == 9) obstruction = 1'b1;
         if (k == 14) obstruction = 1'b0;
      end
      chk("obst_dwell_count", 8'(n_open), 8'd8);

      // Early close, reopen from CLOSING, open+close together
      car_button = 7'd1 << 2;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k == 4) chk("early_open", {7'd0, door_state}, 8'd1);
         if (k == 5) chk("early_close_motor", {6'd0, door_motor}, 8'd2);
         if (k == 7) chk("reopen_motor", {6'd0, door_motor}, 8'd1);
         if (k == 9) chk("reopen_still_opening", {6'd0, door_motor}, 8'd1);
         if (k == 10) chk("reopen_open", {7'd0, door_state}, 8'd1);
         if (k == 12) chk("both_btns_stay_open", {7'd0, door_state}, 8'd1);
         if (k == 14) chk("close_btn_closing", {6'd0, door_motor}, 8'd2);
         if (k == 17) chk("btn_seq_closed", {7'd0, door_closed}, 8'd1);
         case (k)
            1:  car_button = '0;
            4:  close_btn = 1'b1;
            5:  close_btn = 1'b0;
            6:  open_btn = 1'b1;
            7:  open_btn = 1'b0;
            10: begin close_btn = 1'b1; open_btn = 1'b1; end
            12: begin close_btn = 1'b0; open_btn = 1'b0; end
            13: close_btn = 1'b1;
            14: close_btn = 1'b0;
            default: ;
         endcase
      end

      // Car moves with door open: sticky fault, FSM carries on
      car_button = 7'd1 << 2;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 4) chk("fault_before", {7'd0, door_fault}, 8'd0);
         if (k == 5) chk("fault_set", {7'd0, door_fault}, 8'd1);
         if (k == 8) chk("fault_fsm_open", {7'd0, door_state}, 8'd1);
         if (k == 15) chk("fault_sticky", {7'd0, door_fault}, 8'd1);
         if (k == 15) chk("fault_closed", {7'd0, door_closed}, 8'd1);
         if (k == 1) car_button = '0;
         if (k == 4) lift_stopped = 1'b0;
         if (k == 5) lift_stopped = 1'b1;
      end

      // Reset in the middle of OPENING
      car_button = 7'd1 << 2;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 2) chk("midrst_opening", {6'd0, door_motor}, 8'd1);
         if (k == 3) begin
            chk("midrst_door_state", {7'd0, door_state}, 8'd0);
            chk("midrst_door_closed", {7'd0, door_closed}, 8'd1);
            chk("midrst_door_motor", {6'd0, door_motor}, 8'd0);
            chk("midrst_door_fault", {7'd0, door_fault}, 8'd0);
         end
         if (k == 5) chk("midrst_stays_closed", {7'd0, door_closed}, 8'd1);
         if (k == 1) car_button = '0;
         if (k == 2) reset = 1'b1;
         if (k == 3) reset = 1'b0;
      end

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
